// File: rtl/change_dispenser_if.sv
// Signal bundle between the ticket counter / coin hoppers and change_dispenser.
// master drives requests, refills and hopper senses; slave is the dispenser.
interface change_dispenser_if #(
  parameter int CNT_W = 8
);
  logic             change_req;
  logic [3:0]       change_amount;
  logic             refill_100;
  logic             refill_50;
  logic             hop100_sense;
  logic             hop50_sense;
  logic             fault_clr;
  logic             hop100_drive;
  logic             hop50_drive;
  logic             busy;
  logic             done;
  logic             short;
  logic             fault;
  logic [3:0]       remaining;
  logic [CNT_W-1:0] inv100;
  logic [CNT_W-1:0] inv50;
  logic [2:0]       dbg_state;

  // Handshake: change_req is a single-cycle strobe with change_amount, taken
  // only while busy is low; done is a single-cycle strobe and short is valid
  // only alongside it. There is no back-pressure on either side.
  modport master (
    output change_req, change_amount, refill_100, refill_50,
           hop100_sense, hop50_sense, fault_clr,
    input  hop100_drive, hop50_drive, busy, done, short, fault,
           remaining, inv100, inv50, dbg_state
  );

  modport slave (
    input  change_req, change_amount, refill_100, refill_50,
           hop100_sense, hop50_sense, fault_clr,
    output hop100_drive, hop50_drive, busy, done, short, fault,
           remaining, inv100, inv50, dbg_state
  );
endinterface

// File: rtl/change_dispenser.sv
// Greedy change payout through a 100 JPY and a 50 JPY hopper, with coin
// inventory tracking and a jam timeout that parks the block in FAULT.
module change_dispenser #(
  parameter int CNT_W        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int TIMEOUT      = 64
) (
  input logic               clk,
  input logic               reset_n,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SELECT = 3'd1,
    S_DRIVE  = 3'd2,
    S_DONE   = 3'd3,
    S_FAULT  = 3'd4
  } state_e;

  localparam int               TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_PULSE = TMR_W'(PULSE_CYCLES);

  state_e           state_q, state_d;
  logic [3:0]       rem_q, rem_d;
  logic             sel100_q, sel100_d;
  logic             short_q, short_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] inv100_q, inv100_d;
  logic [CNT_W-1:0] inv50_q, inv50_d;
  logic             dec100, dec50;

  // A refill and a payout in the same cycle cancel; both directions clamp.
  function automatic logic [CNT_W-1:0] inv_next(
    input logic [CNT_W-1:0] cur,
    input logic             add,
    input logic             sub
  );
    logic [CNT_W-1:0] r;
    r = cur;
    if (add && !sub) begin
      if (cur != CNT_MAX) r = cur + CNT_W'(1);
    end else if (sub && !add) begin
      if (cur != '0) r = cur - CNT_W'(1);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rem_q    <= '0;
      sel100_q <= 1'b0;
      short_q  <= 1'b0;
      timer_q  <= '0;
      inv100_q <= '0;
      inv50_q  <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      sel100_q <= sel100_d;
      short_q  <= short_d;
      timer_q  <= timer_d;
      inv100_q <= inv100_d;
      inv50_q  <= inv50_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    sel100_d = sel100_q;
    short_d  = short_q;
    timer_d  = timer_q;
    dec100   = 1'b0;
    dec50    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.change_req) begin
          rem_d   = bus.change_amount;
          short_d = 1'b0;
          state_d = S_SELECT;
        end
      end

      S_SELECT: begin
        timer_d = '0;
        if (rem_q >= 4'd2 && inv100_q != '0) begin
          sel100_d = 1'b1;
          state_d  = S_DRIVE;
        end else if (rem_q >= 4'd1 && inv50_q != '0) begin
          sel100_d = 1'b0;
          state_d  = S_DRIVE;
        end else begin
          short_d = (rem_q != 4'd0);
          state_d = S_DONE;
        end
      end

      // A late sense still counts after the drive has dropped; only the
      // timeout gives up on the coin.
      S_DRIVE: begin
        timer_d = timer_q + TMR_W'(1);
        if (sel100_q && bus.hop100_sense) begin
          dec100  = 1'b1;
          rem_d   = rem_q - 4'd2;
          state_d = S_SELECT;
        end else if (!sel100_q && bus.hop50_sense) begin
          dec50   = 1'b1;
          rem_d   = rem_q - 4'd1;
          state_d = S_SELECT;
        end else if (timer_q == TMR_LAST) begin
          state_d = S_FAULT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_FAULT: begin
        if (bus.fault_clr) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    inv100_d = inv_next(inv100_q, bus.refill_100, dec100);
    inv50_d  = inv_next(inv50_q,  bus.refill_50,  dec50);
  end

  logic drive_on;
  assign drive_on = (state_q == S_DRIVE) && (timer_q < TMR_PULSE);

  assign bus.hop100_drive = drive_on &&  sel100_q;
  assign bus.hop50_drive  = drive_on && !sel100_q;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.short        = (state_q == S_DONE) && short_q;
  assign bus.fault        = (state_q == S_FAULT);
  assign bus.remaining    = rem_q;
  assign bus.inv100       = inv100_q;
  assign bus.inv50        = inv50_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Downstream stage of `vending_machine`. It consumes the change request produced when a ticket is dispensed and physically pays that change out through two coin hoppers, 100 JPY and 50 JPY, using a greedy algorithm. It tracks the coin inventory of each hopper and times out on hopper jams. It reports completion, shortfall and fault status back to the ticket counter.

## Interface
Parameters:
- `CNT_W`, 8: width of each hopper inventory counter; counters saturate at 2^CNT_W-1.
- `PULSE_CYCLES`, 4: maximum cycles a hopper drive is held while waiting for its sense pulse.
- `TIMEOUT`, 64: cycles from DRIVE entry without a matching sense before a jam fault is raised; must be greater than `PULSE_CYCLES`.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `change_req` in 1: one-cycle request; sampled only in IDLE.
- `change_amount` in 4: change owed, in 50 JPY units (0..15, i.e. 0..750 JPY); captured with `change_req`.
- `refill_100` in 1: one-cycle pulse that adds one coin to the 100 JPY inventory.
- `refill_50` in 1: one-cycle pulse that adds one coin to the 50 JPY inventory.
- `hop100_sense` in 1: one-cycle pulse when a 100 JPY coin exits the hopper.
- `hop50_sense` in 1: one-cycle pulse when a 50 JPY coin exits the hopper.
- `fault_clr` in 1: one-cycle pulse that clears a jam fault.
- `hop100_drive` out 1: 100 JPY hopper motor drive.
- `hop50_drive` out 1: 50 JPY hopper motor drive.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `short` out 1: valid with `done`; high when change could not be fully paid.
- `fault` out 1: jam fault; high while in the FAULT state.
- `remaining` out 4: units still owed.
- `inv100` out CNT_W: 100 JPY coin inventory.
- `inv50` out CNT_W: 50 JPY coin inventory.

## Operation
States:
- IDLE: waits for a request.
- SELECT: chooses the next coin.
- DRIVE: drives one hopper.
- DONE: reports completion.
- FAULT: holds after a jam.

Transitions:
- IDLE: on `change_req`, load `remaining` from `change_amount` and go to SELECT. `change_req` in any other state is ignored.
- SELECT, coin choice (checked in this order):
  - If `remaining` ≥ 2 and `inv100` > 0: choose the 100 JPY hopper and go to DRIVE.
  - Else if `remaining` ≥ 1 and `inv50` > 0: choose the 50 JPY hopper and go to DRIVE.
  - Else if `remaining` = 0: go to DONE with `short`=0.
  - Else: go to DONE with `short`=1; `remaining` holds the unpaid amount.
- DRIVE:
  - The chosen drive is high for up to `PULSE_CYCLES` cycles starting at DRIVE entry, or until the matching sense arrives.
  - An internal timer counts from DRIVE entry.
  - Matching sense (including one arriving after the drive has dropped): decrement that inventory, subtract 2 (100 JPY) or 1 (50 JPY) from `remaining`, go to SELECT.
  - A sense pulse from the non-chosen hopper is ignored and changes no inventory.
  - Timer reaches `TIMEOUT` without a matching sense: go to FAULT.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- FAULT: both drives low, `busy`=1, `fault`=1, `remaining` frozen. On `fault_clr`, go to IDLE; no `done` pulse is issued for the aborted request.

Inventory:
- A refill increments the counter, saturating at the maximum.
- A refill and a decrement of the same counter in the same cycle leave it unchanged.
- A refill at saturation with no decrement leaves it at the maximum.
- Refills are accepted in every state.

Outputs:
- Each drive is asserted only when its hopper is the chosen one in DRIVE; the two drives are never high together.

## Timing
- Reset (`reset_n`=0 at an edge) takes effect on the next edge, including mid-dispense. Reset values:
  - State IDLE.
  - All drives 0; `busy`, `done`, `short`, `fault` 0.
  - `remaining`, `inv100`, `inv50` 0; timer 0.
- Request latency:
  - `change_req` at edge n: SELECT during cycle n+1, `busy`=1 from cycle n+1.
  - First drive high at cycle n+2.
- Sense latency:
  - Sense sampled at edge m: inventory and `remaining` update at m+1 and the drive drops at m+1.
  - The next drive, if any, starts at m+2 (one SELECT cycle between coins).
- Zero amount: `done`=1 at cycle n+2, `short`=0, IDLE at n+3.
- Short: SELECT sees `remaining`=1 with `inv50`=0, or `remaining` ≥ 2 with both hoppers empty. DONE follows in the next cycle.
- Back-to-back: `busy` drops in the cycle after `done`, so a new `change_req` is accepted two cycles after `done` at the earliest.
- `fault_clr` is ignored outside FAULT. In FAULT it is sampled at edge k and the block is in IDLE at k+1.

## Test plan
- Reset, refill 3×100 and 3×50, request amount 5, answer every drive with its sense two cycles later:
  - Required: two 100 JPY coins then one 50 JPY coin; `done`=1 with `short`=0.
  - Required: `inv100`=1, `inv50`=2, `remaining`=0.
- Inventory of 100=0 and 50=2, request 4:
  - Required: two 50 JPY coins paid, then `done` with `short`=1, `remaining`=2, `inv50`=0.
- Request 2 with 100=1 and no sense ever returned:
  - Required: `hop100_drive` high for 4 cycles; `fault`=1 at DRIVE entry + 64.
  - Required: `inv100` still 1, `remaining`=2.
  - Then `fault_clr`: IDLE next cycle, `busy`=0, no `done` pulse.
- `refill_50` in the same cycle as `hop50_sense` with `inv50`=5: required `inv50`=5 afterwards. Then `hop50_sense` pulses during a 100 JPY drive: required no change to `inv50`.
- Request 0: required `done` two cycles after the request with `short`=0 and no drive asserted. `change_req` asserted while `busy` is high: required to be ignored.
- `reset_n` low during a 100 JPY drive: required all outputs at their reset values on the next edge, and no coin subtracted from the inventory.
